// File: rtl/eb_complement_mw.sv
// eb_complement_mw
//
// Early-bus gate and serial complementer. ORs NSRC early-bus source lines onto a single serial
// bus and, when enabled, converts a serial line between sign-magnitude and two's complement
// (copy up to and including the first 1, invert thereafter). Multi-word lines have the sign
// relocated to the last word. A sticky overflow flag catches adder overflow and negative zero.
//
// Build option: define G15_MULTIWORD_EN for multi-word lines (WORDS honoured, MODE[1] active).
// Without it every word is its own line and WORD_IDX is tied to 0.
//
// Ports:
//   CLOCK     bit-time clock
//   rst       synchronous active-high reset
//   EB_SRC    early-bus source gates, OR-combined into EB
//   TS        sign time, first bit of every word
//   XFER      transfer active
//   MODE      [0] complement enable, [1] multi-word line
//   CLR       program clear of the transfer state (FO unaffected)
//   OVF_ADD   external adder overflow pulse
//   OVF_CLR   overflow test-and-clear
//   IB        intermediate bus (combinational)
//   IS        registered line sign
//   IC        registered complement-active
//   FO        registered sticky overflow
//   WORD_IDX  current word within the line
//   BIT_IDX   current bit within the word
module eb_complement_mw #(
    parameter int unsigned NSRC      = 31,
    parameter int unsigned WORDS     = 2,
    parameter int unsigned WORD_BITS = 29,
    localparam int unsigned WIW      = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int unsigned BIW      = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic [NSRC-1:0]  EB_SRC,
    input  logic             TS,
    input  logic             XFER,
    input  logic [1:0]       MODE,
    input  logic             CLR,
    input  logic             OVF_ADD,
    input  logic             OVF_CLR,
    output logic             IB,
    output logic             IS,
    output logic             IC,
    output logic             FO,
    output logic [WIW-1:0]   WORD_IDX,
    output logic [BIW-1:0]   BIT_IDX
);

    logic           eb;
    logic           ts_go;
    logic           line_start;
    logic           last_word;
    logic           last_bit;
    logic           ib_ts;
    logic           ic_set;
    logic           neg_zero;
    logic           is_q;
    logic           ic_q;
    logic           fo_q;
    logic           fresh_q;    // next TS with XFER high starts a new line at word 0
    logic [BIW-1:0] bit_q;

    assign eb       = |EB_SRC;
    assign ts_go    = XFER & TS;
    assign last_bit = (bit_q == BIW'(WORD_BITS - 1));

`ifdef G15_MULTIWORD_EN
    logic           multi;
    logic [WIW-1:0] word_q;
    logic [WIW-1:0] word_nxt;

    assign multi = MODE[1];

    // Word index the current TS opens; single-word mode makes every TS a line start.
    always_comb begin
        word_nxt = '0;
        if (!fresh_q && multi && (word_q != WIW'(WORDS - 1))) begin
            word_nxt = word_q + 1'b1;
        end
    end

    assign line_start = ts_go && (word_nxt == '0);
    assign last_word  = !multi || (word_q == WIW'(WORDS - 1));

    // Sign is removed from leading words and reappears at the last word's TS.
    always_comb begin
        ib_ts = eb;
        if (multi) begin
            if (word_nxt == WIW'(WORDS - 1)) begin
                ib_ts = line_start ? eb : is_q;
            end else begin
                ib_ts = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst || CLR) begin
            word_q <= '0;
        end else if (ts_go) begin
            word_q <= word_nxt;
        end
    end

    assign WORD_IDX = word_q;
`else
    logic unused_mode_hi;

    assign unused_mode_hi = MODE[1];
    assign line_start     = ts_go;
    assign last_word      = 1'b1;
    assign ib_ts          = eb;
    assign WORD_IDX       = '0;
`endif

    assign ic_set = XFER & ~TS & MODE[0] & is_q & eb;

    // Negative zero: negative sign and no 1 anywhere in the magnitude, this bit included.
    assign neg_zero = XFER & ~TS & MODE[0] & is_q & ~ic_q & ~eb & last_bit & last_word;

    always_comb begin
        IB = eb;
        if (XFER) begin
            if (TS) begin
                IB = ib_ts;
            end else if (MODE[0]) begin
                IB = eb ^ (is_q & ic_q);
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            is_q    <= 1'b0;
            ic_q    <= 1'b0;
            fo_q    <= 1'b0;
            fresh_q <= 1'b1;
            bit_q   <= '0;
        end else begin
            if (OVF_ADD || neg_zero) begin
                fo_q <= 1'b1;
            end else if (OVF_CLR) begin
                fo_q <= 1'b0;
            end

            if (CLR) begin
                is_q    <= 1'b0;
                ic_q    <= 1'b0;
                bit_q   <= '0;
                fresh_q <= 1'b1;
            end else if (!XFER) begin
                fresh_q <= 1'b1;
            end else if (TS) begin
                bit_q   <= BIW'(1);
                fresh_q <= 1'b0;
                if (line_start) begin
                    is_q <= eb;
                    ic_q <= 1'b0;
                end
            end else begin
                bit_q <= last_bit ? '0 : bit_q + 1'b1;
                if (ic_set) begin
                    ic_q <= 1'b1;
                end
            end
        end
    end

    assign IS      = is_q;
    assign IC      = ic_q;
    assign FO      = fo_q;
    assign BIT_IDX = bit_q;

endmodule
